scsi_byte_packer: RTL and testbench

//  SCSI-side DMA front end. Handshakes single bytes out of the WD33C93A over the

---
 rtl/scsi_byte_packer.sv | 186 ++++++++++++++++++
 tb/tb_scsi_byte_packer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scsi_byte_packer.sv
// rtl/scsi_byte_packer.sv - WD33C93A byte handshake, big-endian longword packer and FWFT FIFO
//
// Purpose: reads single bytes from the SCSI controller over the peripheral port
// (_DREQ/_DACK/_IOR), packs them big-endian into longwords and buffers them for
// the bus-master engine. Direction is SCSI -> memory only.
//
// Ports:
//   SCLK        in   1   clock, all state on rising edge
//   RST         in   1   asynchronous active-high reset
//   DMAENA      in   1   DMA running
//   DMADIR      in   1   1 = SCSI -> memory, 0 = stay idle
//   FLUSH       in   1   pulse: drain the partial longword
//   _DREQ       in   1   active-low byte request
//   PD_IN       in   8   peripheral data bus
//   _DACK       out  1   active-low DMA acknowledge
//   _IOR        out  1   active-low read strobe
//   LW_DATA     out  32  head-of-FIFO longword, first byte in [31:24]
//   LW_BYTES    out  3   valid bytes in LW_DATA (1..4, left-justified)
//   LW_VALID    out  1   FIFO not empty
//   LW_READY    in   1   consumer pops on LW_VALID & LW_READY
//   FLUSH_DONE  out  1   pulse: flush complete, packer and FIFO empty

module scsi_byte_packer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2
) (
  input  logic        SCLK,
  input  logic        RST,
  input  logic        DMAENA,
  input  logic        DMADIR,
  input  logic        FLUSH,
  input  logic        _DREQ,
  input  logic [7:0]  PD_IN,
  output logic        _DACK,
  output logic        _IOR,
  output logic [31:0] LW_DATA,
  output logic [2:0]  LW_BYTES,
  output logic        LW_VALID,
  input  logic        LW_READY,
  output logic        FLUSH_DONE
);

  localparam int          AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH       = (AW + 1)'(FIFO_DEPTH);
  localparam logic [7:0]  SETUP_LAST  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0]  STROBE_LAST = 8'(STROBE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RECOVER
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    tmr_q, tmr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [31:0]   data_q, data_d;
  logic          flush_pend_q, flush_pend_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Entry layout: {longword, byte count}
  logic [34:0]   fifo_mem [FIFO_DEPTH];
  logic [34:0]   push_word;
  logic [34:0]   head_word;
  logic          push;
  logic          pop;
  logic          full;

  assign head_word = fifo_mem[rd_ptr_q];
  assign full      = (count_q == DEPTH);
  assign LW_VALID  = (count_q != '0);
  assign pop       = LW_VALID & LW_READY;
  assign LW_DATA   = LW_VALID ? head_word[34:3] : 32'h0;
  assign LW_BYTES  = LW_VALID ? head_word[2:0]  : 3'd0;

  // Strobes are pure decodes of the state register so RST forces them high
  // without waiting for a clock edge.
  assign _DACK = !((state_q == ST_SETUP) || (state_q == ST_STROBE));
  assign _IOR  = (state_q != ST_STROBE);

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    flush_pend_d = flush_pend_q;
    push         = 1'b0;
    push_word    = {data_q, cnt_q};
    FLUSH_DONE   = 1'b0;

    // A repeat FLUSH while pending just re-sets the same bit.
    if (FLUSH) flush_pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (flush_pend_q) begin
          // Pending flush owns IDLE: no new byte starts until it completes.
          if (cnt_q != 3'd0) begin
            if (!full) begin
              push   = 1'b1;
              cnt_d  = 3'd0;
              data_d = 32'h0;
            end
          end else if (count_q == '0) begin
            FLUSH_DONE   = 1'b1;
            flush_pend_d = 1'b0;
          end
        end else if (DMAENA && DMADIR && !_DREQ && !full) begin
          state_d = ST_SETUP;
          tmr_d   = 8'd0;
        end
      end
      ST_SETUP: begin
        if (tmr_q == SETUP_LAST) begin
          state_d = ST_STROBE;
          tmr_d   = 8'd0;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      ST_STROBE: begin
        if (tmr_q == STROBE_LAST) begin
          case (cnt_q[1:0])
            2'd0:    data_d[31:24] = PD_IN;
            2'd1:    data_d[23:16] = PD_IN;
            2'd2:    data_d[15:8]  = PD_IN;
            default: data_d[7:0]   = PD_IN;
          endcase
          cnt_d   = cnt_q + 3'd1;
          state_d = ST_RECOVER;
          tmr_d   = 8'd0;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      default: begin
        // Room is guaranteed: this byte only started while the FIFO had space.
        if (cnt_q == 3'd4) begin
          push      = 1'b1;
          push_word = {data_q, 3'd4};
          cnt_d     = 3'd0;
          data_d    = 32'h0;
        end
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
  end

  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      tmr_q        <= 8'd0;
      cnt_q        <= 3'd0;
      data_q       <= 32'h0;
      flush_pend_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      flush_pend_q <= flush_pend_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset: outputs are masked by LW_VALID.
  always_ff @(posedge SCLK) begin
    if (push) fifo_mem[wr_ptr_q] <= push_word;
  end

endmodule

// File: tb/tb_scsi_byte_packer.sv
// tb/tb_scsi_byte_packer.sv - scoreboard bench for scsi_byte_packer

module tb_scsi_byte_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmaena;
  logic        dmadir;
  logic        flush;
  logic        dreq_n;
  logic [7:0]  pd_in;
  logic        dack_n;
  logic        ior_n;
  logic [31:0] lw_data;
  logic [2:0]  lw_bytes;
  logic        lw_valid;
  logic        lw_ready;
  logic        flush_done;

  scsi_byte_packer dut (
    .SCLK       (clk),
    .RST        (rst),
    .DMAENA     (dmaena),
    .DMADIR     (dmadir),
    .FLUSH      (flush),
    ._DREQ      (dreq_n),
    .PD_IN      (pd_in),
    ._DACK      (dack_n),
    ._IOR       (ior_n),
    .LW_DATA    (lw_data),
    .LW_BYTES   (lw_bytes),
    .LW_VALID   (lw_valid),
    .LW_READY   (lw_ready),
    .FLUSH_DONE (flush_done)
  );

  always #5 clk = ~clk;

  logic [7:0]  bytes_q[$];
  logic [34:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          strobes = 0;
  int          run = 0;
  int          fd_cnt = 0;
  logic        prev_ior = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic void upd_src();
    dreq_n = (bytes_q.size() == 0);
    pd_in  = (bytes_q.size() != 0) ? bytes_q[0] : 8'h00;
  endfunction

  task automatic load(input logic [7:0] b);
    bytes_q.push_back(b);
    upd_src();
  endtask

  task automatic expect_lw(input logic [31:0] d, input logic [2:0] n);
    exp_q.push_back({d, n});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobes(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && strobes < n; i++) tick();
    check(tag, strobes, n);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    check(tag, exp_q.size(), 0);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Peripheral model and output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [34:0] e;
    if (rst) begin
      prev_ior = 1'b1;
      run      = 0;
    end else begin
      if (lw_valid && lw_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", lw_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("lw_data", lw_data, e[34:3]);
          check("lw_bytes", lw_bytes, e[2:0]);
        end
      end
      if (flush_done) begin
        fd_cnt++;
        check("fd_after_pops", exp_q.size(), 0);
        check("fd_fifo_empty", lw_valid, 1'b0);
      end
      if (!ior_n) begin
        run++;
        if (dack_n) check("dack_during_ior", dack_n, 1'b0);
      end else if (!prev_ior) begin
        check("ior_width", run, 2);
        strobes++;
        if (bytes_q.size() != 0) void'(bytes_q.pop_front());
        upd_src();
        run = 0;
      end
      prev_ior = ior_n;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   s;
    int   fd0;
    logic seen_dack;
    logic seen_ior;
    logic seen_valid;

    rst = 1'b1; dmaena = 1'b0; dmadir = 1'b0; flush = 1'b0; lw_ready = 1'b0;
    upd_src();
    repeat (3) tick();
    check("rst_dack", dack_n, 1'b1);
    check("rst_ior", ior_n, 1'b1);
    check("rst_valid", lw_valid, 1'b0);
    check("rst_bytes", lw_bytes, 3'd0);
    check("rst_data", lw_data, 32'h0);
    check("rst_flush_done", flush_done, 1'b0);
    rst = 1'b0;
    tick();

    // T1: reset in the middle of the second byte's strobe
    lw_ready = 1'b1; dmaena = 1'b1; dmadir = 1'b1;
    load(8'hA0); load(8'hB1);
    for (int i = 0; i < 100; i++) begin
      if (strobes == 1 && !ior_n) break;
      tick();
    end
    check("t1_reached", strobes, 1);
    #2 rst = 1'b1;
    #1;
    check("t1_ior", ior_n, 1'b1);
    check("t1_dack", dack_n, 1'b1);
    check("t1_valid", lw_valid, 1'b0);
    bytes_q.delete();
    upd_src();
    tick(); tick();
    rst = 1'b0;
    s = strobes;
    load(8'hC0); load(8'hC1); load(8'hC2); load(8'hC3);
    expect_lw(32'hC0C1C2C3, 3'd4);
    wait_strobes(s + 4, 100, "t1_strobes");
    wait_drain("t1_drain");

    // T2: basic pack
    s = strobes;
    load(8'h00); load(8'hAB); load(8'hCD); load(8'hEF);
    expect_lw(32'h00ABCDEF, 3'd4);
    wait_strobes(s + 4, 100, "t2_strobes");
    wait_drain("t2_drain");

    // T3: back-pressure with the FIFO full
    lw_ready = 1'b0;
    s = strobes;
    for (int b = 1; b <= 20; b++) load(8'(b));
    expect_lw(32'h01020304, 3'd4);
    expect_lw(32'h05060708, 3'd4);
    expect_lw(32'h090A0B0C, 3'd4);
    expect_lw(32'h0D0E0F10, 3'd4);
    expect_lw(32'h11121314, 3'd4);
    wait_strobes(s + 16, 200, "t3_fill");
    seen_dack = 1'b0;
    repeat (30) begin
      tick();
      if (!dack_n) seen_dack = 1'b1;
    end
    check("t3_no_dack_when_full", seen_dack, 1'b0);
    check("t3_held", strobes, s + 16);
    check("t3_valid", lw_valid, 1'b1);
    lw_ready = 1'b1;
    tick();
    lw_ready = 1'b0;
    wait_strobes(s + 17, 40, "t3_resume");
    lw_ready = 1'b1;
    wait_strobes(s + 20, 100, "t3_rest");
    wait_drain("t3_drain");

    // T4: flush a partial longword
    lw_ready = 1'b0;
    s = strobes;
    load(8'h11); load(8'h22); load(8'h33); load(8'h44); load(8'h55); load(8'h66);
    expect_lw(32'h11223344, 3'd4);
    expect_lw(32'h55660000, 3'd2);
    wait_strobes(s + 6, 100, "t4_strobes");
    repeat (3) tick();
    fd0 = fd_cnt;
    pulse_flush();
    repeat (5) tick();
    check("t4_no_early_done", fd_cnt, fd0);
    lw_ready = 1'b1;
    wait_drain("t4_drain");
    repeat (3) tick();
    check("t4_done_once", fd_cnt, fd0 + 1);

    // T5: DMAENA drops mid-strobe
    s = strobes;
    load(8'h77); load(8'h88);
    for (int i = 0; i < 100 && ior_n; i++) tick();
    dmaena = 1'b0;
    wait_strobes(s + 1, 20, "t5_complete");
    seen_dack = 1'b0;
    repeat (40) begin
      tick();
      if (!dack_n) seen_dack = 1'b1;
    end
    check("t5_no_more_dack", seen_dack, 1'b0);
    check("t5_one_byte", strobes, s + 1);
    fd0 = fd_cnt;
    expect_lw(32'h77000000, 3'd1);
    pulse_flush();
    wait_drain("t5_drain");
    repeat (3) tick();
    check("t5_done_once", fd_cnt, fd0 + 1);
    bytes_q.delete();
    upd_src();

    // T6: wrong direction stays idle
    dmaena = 1'b1; dmadir = 1'b0;
    load(8'h01); load(8'h02);
    seen_dack = 1'b0; seen_ior = 1'b0; seen_valid = 1'b0;
    repeat (50) begin
      tick();
      if (!dack_n) seen_dack = 1'b1;
      if (!ior_n) seen_ior = 1'b1;
      if (lw_valid) seen_valid = 1'b1;
    end
    check("t6_dack", seen_dack, 1'b0);
    check("t6_ior", seen_ior, 1'b0);
    check("t6_valid", seen_valid, 1'b0);
    bytes_q.delete();
    upd_src();

    check("final_scoreboard", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
